nbcac_encoder_23: RTL and testbench
===================================

NBCAC_ENCODER_23 -- requirements
Module: nbcac_encoder_23

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the encoded-word counter.
REQ-002 SHALL have port clock, input, 1: rising-edge clock for all state.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low; clock is clock.
REQ-004 SHALL have port din, input, 16: data word to encode.
REQ-005 SHALL have port din_valid, input, 1: din is valid this cycle.
REQ-006 SHALL have port din_ready, output, 1: block accepts din this cycle.
REQ-007 SHALL have port codeout, output, [23:1]: NBCAC codeword driven onto the bus.
REQ-008 SHALL have port code_valid, output, 1: codeout holds a new codeword.
REQ-009 SHALL have port code_ready, input, 1: sink consumes codeout this cycle.
REQ-010 SHALL have port enc_count, output, CNT_W: count of codewords handed off.

Function
REQ-011 SHALL map each din to the unique 23-bit codeword c such that nbcac_16di_decoder_core(c) == din, for all 65536 inputs.
REQ-012 SHALL map din 16'h0000 to codeword 23'h000000.
REQ-013 SHALL accept an input word when din_valid && din_ready at a rising edge.
REQ-014 SHALL be a two-stage pipeline: stage S1 registers din; stage S2 registers the encoded codeword onto codeout.
REQ-015 SHALL assert code_valid exactly 2 cycles after acceptance when there is no back-pressure.
REQ-016 SHALL sustain one word per cycle while code_ready is held high.
REQ-017 SHALL advance S2 when code_valid is low or code_ready is high. S1 SHALL advance into S2 when S1 is valid and S2 advances.
REQ-018 SHALL drive din_ready = !S1_valid || S2_advances, combinationally, with no dependency on din_valid.
REQ-019 SHALL hold codeout and code_valid stable while code_valid && !code_ready, with no data loss or duplication.
REQ-020 SHALL hold codeout at the last emitted codeword when code_valid is low, so the idle bus never toggles.
REQ-021 SHALL, on a simultaneous S2 hand-off and S1 refill in one cycle, load the new codeword into S2 and keep code_valid high.
REQ-022 SHALL preserve input order on output.
REQ-023 SHALL exclude any combinational path from din to codeout.

Reset
REQ-024 SHALL, when rst_n is low, asynchronously clear: S1 data and valid; codeout to 23'h0; code_valid to 0; enc_count to 0.
REQ-025 SHALL drive din_ready to 1 during reset and in the first cycle after reset.
REQ-026 SHALL discard words in flight when reset is asserted mid-operation and emit none of them after release.

Configuration
REQ-027 SHALL, when macro NBCAC_ENC_CNT_EN is defined, increment enc_count by 1 on each code_valid && code_ready, wrapping from 2^CNT_W-1 to 0.
REQ-028 SHALL, when NBCAC_ENC_CNT_EN is undefined, keep the enc_count port, tie it to 0, and instantiate no counter flops.

Structure
REQ-029 SHALL take NBCAC_DATA_W=16, NBCAC_CODE_W=23 and the encoder weight table constants from the shared package nbcac_pkg.
REQ-030 SHALL place the combinational mapping in one sub-module, nbcac_16di_encoder_core (input v[15:0], output d[23:1]), located between S1 and S2.

Verification
REQ-031 SHALL cover reset mapping: din=16'h0000 with code_ready=1 -> code_valid at cycle +2, codeout=23'h000000, enc_count=1 (macro on).
REQ-032 SHALL cover exhaustive round-trip: stream 0..65535 back-to-back with code_ready=1 -> one word per cycle, decoder_core(codeout)==din in order, enc_count=0 after the wrap with CNT_W=16.
REQ-033 SHALL cover back-pressure: send 16'hFFFF then 16'h1234 with code_ready=0 for 5 cycles -> din_ready=0 after 2 accepts, codeout stable; on release, two words emitted in order.
REQ-034 SHALL cover the idle bus: single word 16'hA5A5, then din_valid=0 for 10 cycles -> codeout unchanged, code_valid=0 after the hand-off.
REQ-035 SHALL cover mid-operation reset: rst_n pulsed low while 2 words are in flight -> codeout=0, code_valid=0, enc_count=0 immediately; no stale word after release.
REQ-036 SHALL cover the macro off: run REQ-032 without NBCAC_ENC_CNT_EN -> identical codeouts, enc_count held at 0.

Source files
------------

// File: rtl/nbcac_pkg.sv
// Shared NBCAC constants: data/code widths and the encoder weight table.
// Codewords are Fibonacci (Zeckendorf) representations of the data word:
// bit d[k] carries weight NBCAC_WEIGHT[k], and no two adjacent bits are set.
// This keeps the representation unique, and it bounds coupling between adjacent wires.
package nbcac_pkg;

  localparam int NBCAC_DATA_W = 16;
  localparam int NBCAC_CODE_W = 23;

  // Weight of codeword bit k (k = 1..23): 1, 2, 3, 5, 8, ... 46368.
  localparam logic [NBCAC_DATA_W-1:0] NBCAC_WEIGHT [1:NBCAC_CODE_W] = '{
    16'd1,     16'd2,     16'd3,     16'd5,     16'd8,     16'd13,
    16'd21,    16'd34,    16'd55,    16'd89,    16'd144,   16'd233,
    16'd377,   16'd610,   16'd987,   16'd1597,  16'd2584,  16'd4181,
    16'd6765,  16'd10946, 16'd17711, 16'd28657, 16'd46368
  };

endpackage

// File: rtl/nbcac_16di_encoder_core.sv
// Combinational NBCAC mapping from a 16-bit word to a 23-bit codeword.
// A greedy pass from the heaviest weight down yields the Zeckendorf form.
// That form is the only adjacent-ones-free codeword that decodes back to v.
module nbcac_16di_encoder_core
  import nbcac_pkg::*;
(
  input  logic [NBCAC_DATA_W-1:0] v,
  output logic [NBCAC_CODE_W:1]   d
);

  logic [NBCAC_DATA_W-1:0] rem;

  // Greedy subtraction of Fibonacci weights, most significant first.
  always_comb begin
    d   = '0;
    rem = v;
    for (int k = NBCAC_CODE_W; k >= 1; k--) begin
      if (rem >= NBCAC_WEIGHT[k]) begin
        d[k] = 1'b1;
        rem  = rem - NBCAC_WEIGHT[k];
      end
    end
  end

endmodule

// File: rtl/nbcac_encoder_23.sv
// NBCAC 16-bit to 23-bit bus encoder with a two-stage valid/ready pipeline.
// S1 registers din.  S2 registers the encoded word onto codeout.
// codeout holds its last value while idle, so the bus does not toggle.
// Optional macro NBCAC_ENC_CNT_EN enables the enc_count hand-off counter.
// When the macro is undefined, enc_count is tied to zero.
module nbcac_encoder_23
  import nbcac_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic [NBCAC_DATA_W-1:0] din,
  input  logic                    din_valid,
  output logic                    din_ready,
  output logic [NBCAC_CODE_W:1]   codeout,
  output logic                    code_valid,
  input  logic                    code_ready,
  output logic [CNT_W-1:0]        enc_count
);

  logic [NBCAC_DATA_W-1:0] din_p1;
  logic                    vld_p1;
  logic [NBCAC_CODE_W:1]   code_nxt_p1;
  logic [NBCAC_CODE_W:1]   code_p2;
  logic                    vld_p2;
  logic                    s2_adv;
  logic                    accept;

  assign s2_adv     = !vld_p2 || code_ready;
  assign din_ready  = !vld_p1 || s2_adv;
  assign accept     = din_valid && din_ready;
  assign codeout    = code_p2;
  assign code_valid = vld_p2;

  // ---- stage S1: capture the input word ----
  // S1 is filled on acceptance; otherwise it drains when S2 takes its word.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      din_p1 <= '0;
      vld_p1 <= 1'b0;
    end else if (accept) begin
      din_p1 <= din;
      vld_p1 <= 1'b1;
    end else if (s2_adv) begin
      vld_p1 <= 1'b0;
    end
  end

  nbcac_16di_encoder_core u_core (
    .v (din_p1),
    .d (code_nxt_p1)
  );

  // ---- stage S2: registered codeword on the bus ----
  // codeout only loads real words, so it holds the last codeword while idle.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      code_p2 <= '0;
      vld_p2  <= 1'b0;
    end else if (s2_adv) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        code_p2 <= code_nxt_p1;
      end
    end
  end

`ifdef NBCAC_ENC_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Count completed hand-offs; wraps naturally at 2^CNT_W.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (vld_p2 && code_ready) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign enc_count = cnt_q;
`else
  assign enc_count = '0;
`endif

endmodule

// File: tb/tb_nbcac_encoder_23.sv
// Directed bench for nbcac_encoder_23: reset, latency, back-pressure, idle bus,
// mid-operation reset and an exhaustive in-order round-trip of all 65536 words.
module tb_nbcac_encoder_23;

  logic        clock = 1'b0;
  logic        rst_n;
  logic [15:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [23:1] codeout;
  logic        code_valid;
  logic        code_ready;
  logic [15:0] enc_count;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_cnt = '0;

  nbcac_encoder_23 #(.CNT_W(16)) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .codeout    (codeout),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .enc_count  (enc_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bump();
`ifdef NBCAC_ENC_CNT_EN
    exp_cnt = exp_cnt + 16'd1;
`endif
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("%s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Independent decoder: sum of Fibonacci weights 1,2,3,5,... over set bits.
  function automatic int unsigned dec(input logic [22:0] c);
    int unsigned a = 1;
    int unsigned b = 2;
    int unsigned s = 0;
    int unsigned t;
    for (int i = 0; i < 23; i++) begin
      if (c[i]) s += a;
      t = a + b;
      a = b;
      b = t;
    end
    return s;
  endfunction

  initial begin
    int bad_dec, bad_adj, bad_vld, bad_rdy;
    logic [22:0] cw;

    // Reset state
    rst_n = 1'b0; din = '0; din_valid = 1'b0; code_ready = 1'b1;
    tick(); tick();
    chk("rst_code_valid", {31'd0, code_valid}, 32'd0);
    chk("rst_codeout", {9'd0, codeout}, 32'h0);
    chk("rst_din_ready", {31'd0, din_ready}, 32'd1);
    chk("rst_enc_count", {16'd0, enc_count}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_din_ready", {31'd0, din_ready}, 32'd1);

    // Zero word: two-cycle latency, all-zero codeword
    din = 16'h0000; din_valid = 1'b1; code_ready = 1'b1;
    tick();
    din_valid = 1'b0;
    chk("zero_lat1_valid", {31'd0, code_valid}, 32'd0);
    tick();
    chk("zero_lat2_valid", {31'd0, code_valid}, 32'd1);
    chk("zero_codeout", {9'd0, codeout}, 32'h0);
    tick(); bump();
    chk("zero_after_valid", {31'd0, code_valid}, 32'd0);
    chk("zero_enc_count", {16'd0, enc_count}, {16'd0, exp_cnt});

    // Back-pressure: FFFF then 1234 with the sink stalled
    code_ready = 1'b0; din = 16'hFFFF; din_valid = 1'b1;
    tick();
    din = 16'h1234;
    chk("bp_ready_2nd", {31'd0, din_ready}, 32'd1);
    tick();
    din_valid = 1'b0;
    chk("bp_ready_full", {31'd0, din_ready}, 32'd0);
    chk("bp_valid", {31'd0, code_valid}, 32'd1);
    chk("bp_code_ffff", {9'd0, codeout}, 32'h505204);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_code", {9'd0, codeout}, 32'h505204);
      chk("bp_hold_valid", {31'd0, code_valid}, 32'd1);
      chk("bp_hold_ready", {31'd0, din_ready}, 32'd0);
    end
    code_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, din_ready}, 32'd1);
    tick(); bump();
    chk("bp_code_1234", {9'd0, codeout}, 32'h021220);
    chk("bp_valid_2nd", {31'd0, code_valid}, 32'd1);
    tick(); bump();
    chk("bp_drained_valid", {31'd0, code_valid}, 32'd0);
    chk("bp_drained_code", {9'd0, codeout}, 32'h021220);
    chk("bp_enc_count", {16'd0, enc_count}, {16'd0, exp_cnt});

    // Idle bus after a single A5A5
    din = 16'hA5A5; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    tick();
    chk("idle_code_a5a5", {9'd0, codeout}, 32'h290529);
    chk("idle_valid", {31'd0, code_valid}, 32'd1);
    tick(); bump();
    for (int i = 0; i < 10; i++) begin
      chk("idle_hold_code", {9'd0, codeout}, 32'h290529);
      chk("idle_hold_valid", {31'd0, code_valid}, 32'd0);
      tick();
    end
    chk("idle_enc_count", {16'd0, enc_count}, {16'd0, exp_cnt});

    // Mid-operation reset with two words in flight
    code_ready = 1'b0; din = 16'h0001; din_valid = 1'b1;
    tick();
    din = 16'h0002;
    tick();
    din_valid = 1'b0;
    chk("mid_inflight_code", {9'd0, codeout}, 32'h000001);
    chk("mid_inflight_valid", {31'd0, code_valid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    exp_cnt = '0;
    chk("mid_rst_code", {9'd0, codeout}, 32'h0);
    chk("mid_rst_valid", {31'd0, code_valid}, 32'd0);
    chk("mid_rst_count", {16'd0, enc_count}, 32'd0);
    chk("mid_rst_ready", {31'd0, din_ready}, 32'd1);
    tick();
    rst_n = 1'b1; code_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_no_stale_valid", {31'd0, code_valid}, 32'd0);
      chk("mid_no_stale_code", {9'd0, codeout}, 32'h0);
    end

    // Exhaustive back-to-back round trip
    bad_dec = 0; bad_adj = 0; bad_vld = 0; bad_rdy = 0;
    code_ready = 1'b1;
    for (int k = 0; k <= 65536; k++) begin
      din = 16'(k);
      din_valid = (k < 65536);
      if (k < 65536 && din_ready !== 1'b1) bad_rdy++;
      tick();
      if (k >= 1) begin
        if (code_valid !== 1'b1) bad_vld++;
        else begin
          cw = codeout;
          if (dec(cw) != 32'(k - 1)) bad_dec++;
          if ((cw & (cw >> 1)) != 23'd0) bad_adj++;
        end
      end else if (code_valid !== 1'b0) bad_vld++;
    end
    din_valid = 1'b0;
    tick();
    for (int k = 0; k < 65536; k++) bump();
    chk("exh_decode_errors", 32'(bad_dec), 32'd0);
    chk("exh_adjacent_ones", 32'(bad_adj), 32'd0);
    chk("exh_valid_gaps", 32'(bad_vld), 32'd0);
    chk("exh_ready_drops", 32'(bad_rdy), 32'd0);
    chk("exh_final_valid", {31'd0, code_valid}, 32'd0);
    chk("exh_final_code", {9'd0, codeout}, 32'h505204);
    chk("exh_enc_count", {16'd0, enc_count}, {16'd0, exp_cnt});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
